// File: rtl/alu_ctrl_pkg.sv
// Shared widths, FSM state encoding and ALU opcode names for the
// ALU arbiter and its ALU.
package alu_ctrl_pkg;

  localparam int DATA_W = 6;
  localparam int OP_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational 6-bit ALU. Arithmetic wraps at DATA_W bits, and the
// result is not extended and carries no flags.
module alu_arbiter_alu
  import alu_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    out = '0;
    case (alu_op_e'(op))
      ALU_ADD: out = A + B;
      ALU_SUB: out = A - B;
      ALU_AND: out = A & B;
      ALU_XOR: out = A ^ B;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around one shared ALU. Requests are served one at a
// time (IDLE -> EXEC -> DONE), and round-robin priority is applied when both requesters collide.
module alu_arbiter #(
  parameter int DATA_W = alu_ctrl_pkg::DATA_W,
  parameter int OP_W   = alu_ctrl_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [OP_W-1:0]   op0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [OP_W-1:0]   op1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] res,
  output logic              res_valid,
  output logic              res_owner,
  input  logic              res_ready,
  output logic [7:0]        op_count
);

  import alu_ctrl_pkg::state_e;
  import alu_ctrl_pkg::IDLE;
  import alu_ctrl_pkg::EXEC;
  import alu_ctrl_pkg::DONE;

  state_e            state;
  logic              prio;
  logic              cur_owner;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic [OP_W-1:0]   cap_op;
  logic [DATA_W-1:0] alu_out;
  logic              pick1;

  // A lone request always wins, and the pointer only breaks ties.
  assign pick1 = req1 & (~req0 | prio);

  alu_arbiter_alu u_alu (
    .A  (cap_a),
    .B  (cap_b),
    .op (cap_op),
    .out(alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cur_owner <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      res_owner <= 1'b0;
      op_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cur_owner <= pick1;
            cap_a     <= pick1 ? a1  : a0;
            cap_b     <= pick1 ? b1  : b0;
            cap_op    <= pick1 ? op1 : op0;
            ack0      <= ~pick1;
            ack1      <= pick1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          res       <= alu_out;
          res_owner <= cur_owner;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            prio      <= ~res_owner;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. It applies a vector table of single transactions
// and then runs hand-written sequences for collision, stall, mid-flight reset and counter wrap.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [5:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       ack0, ack1;
  logic [5:0] res;
  logic       res_valid, res_owner, res_ready;
  logic [7:0] op_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_count;

  typedef struct {
    logic       r0, r1;
    logic [5:0] a0, b0;
    logic [1:0] op0;
    logic [5:0] a1, b1;
    logic [1:0] op1;
    logic       owner;
    logic [5:0] res;
  } vec_t;

  vec_t vecs[7];

  alu_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .op0      (op0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .op1      (op1),
    .ack0     (ack0),
    .ack1     (ack1),
    .res      (res),
    .res_valid(res_valid),
    .res_owner(res_owner),
    .res_ready(res_ready),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 8'd0;
  endtask

  // One isolated transaction from IDLE, with the consumer always ready.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    req0 = v.r0; a0 = v.a0; b0 = v.b0; op0 = v.op0;
    req1 = v.r1; a1 = v.a1; b1 = v.b1; op1 = v.op1;
    res_ready = 1'b1;
    @(negedge clk);
    check("txn_ack0", ack0, v.owner == 1'b0);
    check("txn_ack1", ack1, v.owner == 1'b1);
    check("txn_early_valid", res_valid, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("txn_valid", res_valid, 1);
    check("txn_res", res, v.res);
    check("txn_owner", res_owner, v.owner);
    check("txn_ack_cleared", ack0 | ack1, 0);
    @(negedge clk);
    exp_count = exp_count + 8'd1;
    check("txn_valid_cleared", res_valid, 0);
    check("txn_op_count", op_count, exp_count);
  endtask

  initial begin
    // Fields: r0, r1, a0, b0, op0, a1, b1, op1, owner, res
    vecs[0] = '{1'b1, 1'b0, 6'h3B, 6'd20, 2'd0, 6'd0,  6'd0,  2'd0, 1'b0, 6'd15}; // -5+20
    vecs[1] = '{1'b1, 1'b0, 6'd5,  6'd20, 2'd2, 6'd0,  6'd0,  2'd0, 1'b0, 6'd4};  // lone req0 against pointer=1
    vecs[2] = '{1'b0, 1'b1, 6'd0,  6'd0,  2'd0, 6'd5,  6'd10, 2'd1, 1'b1, 6'd59}; // 5-10 = -5
    vecs[3] = '{1'b0, 1'b1, 6'd0,  6'd0,  2'd0, 6'd31, 6'd1,  2'd0, 1'b1, 6'd32}; // +31+1 wraps
    vecs[4] = '{1'b1, 1'b0, 6'h20, 6'd1,  2'd1, 6'd0,  6'd0,  2'd0, 1'b0, 6'd31}; // -32-1 wraps
    vecs[5] = '{1'b1, 1'b0, 6'h3D, 6'h36, 2'd3, 6'd0,  6'd0,  2'd0, 1'b0, 6'd11}; // -3 ^ -10
    vecs[6] = '{1'b0, 1'b1, 6'd0,  6'd0,  2'd0, 6'h3F, 6'h3F, 2'd0, 1'b1, 6'd62}; // -1 + -1

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    exp_count = 8'd0;

    repeat (2) @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_res", res, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_owner", res_owner, 0);
    check("rst_op_count", op_count, 0);

    // Both requesting out of reset: 0 first, then 1; first grant on first edge.
    req0 = 1'b1; a0 = 6'd5; b0 = 6'd20; op0 = 2'd2;
    req1 = 1'b1; a1 = 6'd5; b1 = 6'd10; op1 = 2'd1;
    res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("both_first_ack0", ack0, 1);
    check("both_first_ack1", ack1, 0);
    req0 = 1'b0;
    @(negedge clk);
    check("both_first_valid", res_valid, 1);
    check("both_first_res", res, 4);
    check("both_first_owner", res_owner, 0);
    @(negedge clk);
    check("both_first_count", op_count, 1);
    @(negedge clk);
    check("both_second_ack1", ack1, 1);
    check("both_second_ack0", ack0, 0);
    req1 = 1'b0;
    @(negedge clk);
    check("both_second_valid", res_valid, 1);
    check("both_second_res", res, 59);
    check("both_second_owner", res_owner, 1);
    @(negedge clk);
    check("both_second_count", op_count, 2);
    exp_count = 8'd2;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Continuous contention: owners must alternate 0,1,0,1,0,1.
    do_reset();
    req0 = 1'b1; a0 = 6'd1; b0 = 6'd2; op0 = 2'd0;
    req1 = 1'b1; a1 = 6'd7; b1 = 6'd3; op1 = 2'd1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit got = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          got = 1'b1;
          break;
        end
      end
      check("alt_ack_seen", got, 1);
      check("alt_ack_onehot", ack0 & ack1, 0);
      check("alt_grant_owner", ack1, i % 2);
      @(negedge clk);
      check("alt_res_owner", res_owner, i % 2);
      check("alt_res", res, (i % 2) ? 6'd4 : 6'd3);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Consumer stall in DONE: result holds and no re-grant while requests stay high.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; a0 = 6'h3D; b0 = 6'h36; op0 = 2'd3;
    res_ready = 1'b0;
    @(negedge clk);
    check("stall_ack0", ack0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_res", res, 11);
      check("stall_owner", res_owner, 0);
      check("stall_no_ack", ack0 | ack1, 0);
      check("stall_count", op_count, 0);
    end
    req0 = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", res_valid, 0);
    check("stall_release_count", op_count, 1);

    // Reset pulsed during EXEC discards the transaction.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; a0 = 6'd3; b0 = 6'd2; op0 = 2'd1;
    res_ready = 1'b1;
    @(negedge clk);
    check("midrst_ack0", ack0, 1);
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_async_ack0", ack0, 0);
    check("midrst_async_valid", res_valid, 0);
    check("midrst_async_res", res, 0);
    check("midrst_async_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_valid", res_valid, 0);
    check("midrst_count", op_count, 0);
    exp_count = 8'd0;
    begin
      vec_t v;
      v = '{1'b0, 1'b1, 6'd0, 6'd0, 2'd0, 6'd3, 6'd2, 2'd1, 1'b1, 6'd1};
      run_txn(v);
    end

    // 256 transactions wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_txn(vecs[i % 7]);
      if (i == 254) check("count_255", op_count, 255);
    end
    check("count_wrap", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 6, operand/result width; only 6 is supported, matching the shared 6-bit ALU.
REQ-002 Parameter: OP_W, 2, operation-select width; opcode values 0..3 are passed to the ALU unmodified.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0 / req1  input  1 each  request from requester 0 / 1; held high with its operands stable until the matching ack.
REQ-006 a0, b0 / a1, b1  input  DATA_W each  two's-complement operands of requester 0 / 1.
REQ-007 op0 / op1  input  OP_W each  ALU operation select of requester 0 / 1.
REQ-008 ack0 / ack1  output  1 each  one-cycle pulse: request captured.
REQ-009 res  output  DATA_W  registered ALU result.
REQ-010 res_valid  output  1  res and res_owner valid.
REQ-011 res_owner  output  1  requester index that owns res.
REQ-012 res_ready  input  1  consumer accepts res in any cycle where res_valid and res_ready are both high.
REQ-013 op_count  output  8  number of completed transactions, wraps 255->0.

Function
REQ-014 FSM states: IDLE, EXEC, DONE.
REQ-015 IDLE, no req: remain in IDLE; all outputs hold.
REQ-016 IDLE, exactly one req high: grant that requester regardless of the priority pointer.
REQ-017 IDLE, both req high: grant the requester selected by the priority pointer.
REQ-018 On the granting edge: capture a/b/op of the granted requester into internal registers, record the owner, set state to EXEC.
REQ-019 The granted requester's ack is high for exactly the cycle following the granting edge; the other ack stays low.
REQ-020 EXEC lasts one cycle: the ALU is driven from the captured registers, and the ALU output is registered into res at the EXEC->DONE edge.
REQ-021 res_valid goes high on entry to DONE; request-capture-to-res_valid latency is 2 cycles.
REQ-022 DONE: res, res_owner and res_valid hold stable until res_valid && res_ready.
REQ-023 On the accepting edge, all of the following take effect: res_valid clears, op_count increments, the priority pointer is set to the requester that was not served, and state returns to IDLE.
REQ-024 A new grant occurs no earlier than the cycle after IDLE re-entry; throughput is at most one transaction per 3 cycles.
REQ-025 A request arriving or dropping while in EXEC or DONE is ignored until IDLE; dropping a request before its ack is a protocol violation with no required behaviour.
REQ-026 The result is the ALU's native DATA_W-bit output; no overflow flag or extension is applied, and wrap follows the ALU.
REQ-027 Alternation: with both requesters continuously requesting, grants strictly alternate 0,1,0,1,...

Reset
REQ-028 rst_n low asynchronously forces state IDLE, priority pointer to requester 0, ack0=ack1=0, res=0, res_valid=0, res_owner=0, op_count=0, and clears the captured operand registers.
REQ-029 Reset asserted in EXEC or DONE discards the in-flight transaction: no res_valid, and op_count is unchanged from its reset value.
REQ-030 After rst_n deasserts, the first grant may occur on the first rising edge.

Structure
REQ-031 Shared package alu_ctrl_pkg holds DATA_W, OP_W and the FSM state encoding.
REQ-032 Exactly one sub-module: the existing combinational 6-bit ALU (ports A, B, op, out), instantiated once and fed only from the captured registers.

Verification
REQ-033 Only req0=1, a0=-5, b0=20, op0=0: ack0 pulses 1 cycle after the grant edge; res_valid is high 2 cycles after capture; res equals the standalone ALU output for (-5,20,0); res_owner=0.
REQ-034 req0 and req1 asserted together from reset, with req1 a1=5, b1=10, op1=1 and req0 a0=5, b0=20, op0=2, res_ready=1: requester 0 is served first, then requester 1; results match the ALU for each operand set; op_count reaches 2.
REQ-035 Both requests held continuously for 6 transactions: owners are 0,1,0,1,0,1.
REQ-036 res_ready=0 for 5 cycles in DONE (a0=-3, b0=-10, op0=3): res and res_valid are stable; no second ack is issued; completion occurs on the first cycle res_ready=1.
REQ-037 rst_n pulsed low during EXEC (a0=3, b0=2, op0=1): all outputs return to 0 immediately; no res_valid; the next request is served normally.
REQ-038 256 single transactions: op_count wraps to 0.
